// File: rtl/sram_model_pkg.sv
// rtl/sram_model_pkg.sv - shared types and helpers for the single-port SRAM model
package sram_model_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_DONE = 1'b1
    } init_state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // Masked write merge for one bit: a low mask bit takes the new data,
    // a high mask bit keeps the stored value.
    function automatic logic merge_bit(logic old_bit, logic new_bit, logic bweb_bit);
        return (old_bit & bweb_bit) | (new_bit & ~bweb_bit);
    endfunction

endpackage

// File: rtl/sram_sp_bwe_model_if.sv
// rtl/sram_sp_bwe_model_if.sv - request/response bundle of the single-port SRAM model
interface sram_sp_bwe_model_if #(
    parameter int Bits      = 128,
    parameter int Add_Width = 5
);
    logic                 CEB;
    logic                 WEB;
    logic [Bits-1:0]      BWEB;
    logic [Add_Width-1:0] A;
    logic [Bits-1:0]      D;
    logic [Bits-1:0]      Q;
    logic                 INIT_DONE;

    modport master (
        output CEB, WEB, BWEB, A, D,
        input  Q, INIT_DONE
    );

    modport slave (
        input  CEB, WEB, BWEB, A, D,
        output Q, INIT_DONE
    );
endinterface

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - post-reset clear sweep sequencer
module sram_init_seq
    import sram_model_pkg::*;
#(
    parameter int Word_Depth = 32,
    parameter int Add_Width  = 5,
    parameter int INIT_EN    = 1
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    output logic                 init_done,
    output logic [Add_Width-1:0] sweep_addr,
    output logic                 sweep_we
);

    localparam logic [Add_Width-1:0] LAST_ADDR = Add_Width'(Word_Depth - 1);
    localparam logic [Add_Width-1:0] ONE       = Add_Width'(1);

    init_state_e          state;
    logic [Add_Width-1:0] cnt;

    // Sweep one word per edge; the edge writing the last word finishes the sweep.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= (INIT_EN != 0) ? ST_INIT : ST_DONE;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + ONE;
                    if (cnt == LAST_ADDR) begin
                        state     <= ST_DONE;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    assign sweep_addr = cnt;
    assign sweep_we   = (state == ST_INIT);

endmodule

// File: rtl/sram_sp_bwe_model.sv
// rtl/sram_sp_bwe_model.sv - single-port SRAM model with bit write mask, init sweep, 1/2-cycle read
module sram_sp_bwe_model
    import sram_model_pkg::*;
#(
    parameter int              Bits       = 128,
    parameter int              Word_Depth = 32,
    parameter int              Add_Width  = 5,
    parameter int              LATENCY    = 1,
    parameter int              INIT_EN    = 1,
    parameter logic [Bits-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    sram_sp_bwe_model_if.slave    bus
);

    if ((LATENCY != LAT_MIN && LATENCY != LAT_MAX) || ((2 ** Add_Width) < Word_Depth)) begin : g_bad_param
        $error("sram_sp_bwe_model: illegal LATENCY or Add_Width too small for Word_Depth");
    end

    localparam logic [Add_Width:0] DEPTH = (Add_Width + 1)'(Word_Depth);

    logic                 init_done;
    logic [Add_Width-1:0] sweep_addr;
    logic                 sweep_we;

    sram_init_seq #(
        .Word_Depth (Word_Depth),
        .Add_Width  (Add_Width),
        .INIT_EN    (INIT_EN)
    ) u_init_seq (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .init_done  (init_done),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    logic [Bits-1:0] ram [Word_Depth];

    logic            in_range;
    logic            wr_en;
    logic            rd_en;
    logic [Bits-1:0] rd_word;
    logic [Bits-1:0] wr_word;
    logic [Bits-1:0] q_r;

    // Requests are only honoured once the sweep is finished.
    assign in_range = ({1'b0, bus.A} < DEPTH);
    assign wr_en    = init_done & ~bus.CEB & ~bus.WEB & in_range;
    assign rd_en    = init_done & ~bus.CEB &  bus.WEB;
    assign rd_word  = in_range ? ram[bus.A] : '0;

    // Merge the masked write data with the currently stored word.
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < Bits; i++) begin
            wr_word[i] = merge_bit(ram[bus.A][i], bus.D[i], bus.BWEB[i]);
        end
    end

    // Array write port: sweep and user writes never overlap because user
    // writes require init_done, which is only set after the sweep ends.
    always_ff @(posedge CLK) begin
        if (RSTB) begin
            if (sweep_we) begin
                ram[sweep_addr] <= INIT_VALUE;
            end else if (wr_en) begin
                ram[bus.A] <= wr_word;
            end
        end
    end

    if (LATENCY == LAT_MAX) begin : g_lat2
        logic            s1_valid;
        logic [Bits-1:0] s1_data;

        // Two-stage read: sample the array at issue, present on the next edge.
        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
                q_r      <= '0;
            end else begin
                s1_valid <= rd_en;
                if (rd_en) begin
                    s1_data <= rd_word;
                end
                if (s1_valid) begin
                    q_r <= s1_data;
                end
            end
        end
    end else begin : g_lat1
        // Single-stage read: Q updates on the issuing edge, otherwise holds.
        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                q_r <= '0;
            end else if (rd_en) begin
                q_r <= rd_word;
            end
        end
    end

    assign bus.Q         = q_r;
    assign bus.INIT_DONE = init_done;

endmodule
